seq_match_ctrl: RTL
===================

// Module: seq_match_ctrl
// PURPOSE
//  Shares one serial pattern-match engine between N_REQ requesters (CAN frame
//  sync, error-flag and overload-flag detectors). Arbitrates round-robin, latches
//  the winner's PAT_W-bit pattern and mask, then scans the sampled CAN bit stream
//  for up to WIN_LEN valid bits. Reports hit/timeout and hit position to the
//  winning requester. Sits after the bit-timing sample point, ahead of frame decode.
// PARAMETERS
//  N_REQ   2   number of requesters (>=2)
//  PAT_W   8   pattern width, bits
//  WIN_LEN 64  max valid bits scanned per request before timeout
//  CNT_W   7   bit-counter width; must satisfy 2**CNT_W > WIN_LEN
// PORTS
//  clk       in   1            system clock, single clock domain
//  rst       in   1            synchronous reset, active-high
//  req       in   N_REQ        per-requester request level; hold until done
//  pat       in   N_REQ*PAT_W  patterns, requester i at [i*PAT_W +: PAT_W]
//  msk       in   N_REQ*PAT_W  care masks, 1 = compare bit, 0 = don't-care
//  din       in   1            sampled CAN bit, LSB-first pattern order
//  bit_vld   in   1            1-cycle strobe: din valid this cycle
//  gnt       out  N_REQ        one-hot grant, held for whole operation
//  busy      out  1            1 in any state other than IDLE
//  done      out  1            1-cycle pulse: operation complete
//  hit       out  1            valid with done: 1 = match, 0 = timeout
//  hit_pos   out  CNT_W        valid with done: count of valid bits consumed
//  done_id   out  N_REQ        valid with done: one-hot id of finished requester
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer -> requester 0, window/count cleared.
//  States, one-hot: IDLE=4'b0001, LOAD=4'b0010, SCAN=4'b0100, DONE=4'b1000.
//  IDLE: any req set -> round-robin pick starting at pointer; gnt registered,
//   asserted cycle t+1 for req seen at t; -> LOAD. Pointer = winner+1 (mod N_REQ).
//  LOAD: one cycle; latch pat/msk of winner, clear window, fill and bit counters;
//   -> SCAN. Pattern changes after LOAD are ignored.
//  SCAN: on bit_vld: window <= {din, window[PAT_W-1:1]}; fill saturates at PAT_W;
//   bit counter +1. No bit_vld -> nothing changes.
//   match = (fill==PAT_W, counting the current bit) && ((window_next ^ pat) & msk)==0.
//   match -> DONE, hit=1. Else counter reaches WIN_LEN -> DONE, hit=0.
//   Match on the WIN_LEN-th bit: hit wins. All-zero mask: match once fill full.
//  DONE: done=1, hit, hit_pos=counter, done_id=gnt for exactly this cycle;
//   gnt drops in the same cycle; -> IDLE. Earliest re-grant is 2 cycles after done.
//  Abort: granted req drops in LOAD/SCAN -> IDLE next cycle, no done, gnt cleared,
//   pointer unchanged from grant time.
//  Non-granted req changes while busy: ignored; served in later rr order.
//  rst mid-operation: immediate return to reset values; no done pulse.
//  hit_pos width rule: counter never exceeds WIN_LEN; no wrap.
//  Latency: req -> gnt 1 cycle; gnt -> scanning 1 cycle; final bit_vld -> done 1 cycle.
// STRUCTURE
//  Shared package seq_pkg: state encodings, default PAT_W/WIN_LEN, CNT_W rule.
//  Sub-module rr_arbiter (N_REQ param; req, advance -> one-hot gnt, pointer reg).
//  Top: FSM, pattern/mask latches, PAT_W shift window, fill and bit counters.
// TESTING
//  1 reset: rst 3 cycles with req=2'b11 -> gnt=0, busy=0, done=0 throughout.
//  2 req0 pat=8'hA5 msk=8'hFF, stream 5 noise bits then A5 LSB-first -> done,
//    hit=1, hit_pos=13, done_id=2'b01.
//  3 req=2'b11 held, both patterns never sent -> gnt 01 then 10 alternate; each
//    done has hit=0, hit_pos=64.
//  4 msk=8'h0F pat=8'h0A, stream with low nibble 4'hA, high nibble random
//    -> hit=1 at 8th valid bit, hit_pos=8.
//  5 bit_vld gapped 1-in-4, pattern on bits 57..64 -> hit=1, hit_pos=64 (hit wins).
//  6 drop req0 mid-SCAN, then rst mid-SCAN on req1 -> no done; gnt=0 next cycle;
//    req1 re-granted 1 cycle after rst released.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern-match controller: FSM encoding,
// default sizing and small index/width helpers.
package seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_LOAD = 4'b0010,
        ST_SCAN = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    localparam int DEF_N_REQ   = 2;
    localparam int DEF_PAT_W   = 8;
    localparam int DEF_WIN_LEN = 64;

    // Bit counter must hold WIN_LEN itself, so it needs clog2(WIN_LEN+1) bits.
    function automatic int cnt_w_min(input int win_len);
        return $clog2(win_len + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_w_min(DEF_WIN_LEN);

    // (base + off) mod n for base, off < n, without a divider.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a pointer; the
// pointer moves to winner+1 only when the caller accepts the grant (advance).
module rr_arbiter
    import seq_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic             found;
    int               idx;

    // First requester at or after the pointer wins.
    always_comb begin
        gnt     = '0;
        win_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = wrap_idx(int'(ptr), i, N_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win_idx  = PTR_W'(idx);
            end
        end
    end

    // Pointer moves past the accepted winner so it is lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Shared serial pattern-match engine. Grants one requester round-robin,
// latches its pattern/mask, then shifts sampled CAN bits into a window until
// the masked window matches or the bit budget runs out.
module seq_match_ctrl
    import seq_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int PAT_W   = DEF_PAT_W,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PAT_W-1:0] pat,
    input  logic [N_REQ*PAT_W-1:0] msk,
    input  logic                   din,
    input  logic                   bit_vld,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic [CNT_W-1:0]       hit_pos,
    output logic [N_REQ-1:0]       done_id
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    state_t             state;
    logic [N_REQ-1:0]   arb_gnt;
    logic               advance;
    logic               owner_live;
    logic [PAT_W-1:0]   pat_sel, msk_sel;
    logic [PAT_W-1:0]   pat_q, msk_q;
    logic [PAT_W-1:0]   win, win_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               match;
    logic               budget_out;

    // The arbiter pointer only advances when IDLE actually takes a grant.
    assign advance = (state == ST_IDLE) && (|req);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .gnt     (arb_gnt)
    );

    // Select the granted requester's pattern and mask for latching in LOAD.
    always_comb begin
        pat_sel = '0;
        msk_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                pat_sel = pat[i*PAT_W +: PAT_W];
                msk_sel = msk[i*PAT_W +: PAT_W];
            end
        end
    end

    // Oldest bit sits at window[0], so patterns are compared LSB-first.
    assign win_nxt    = {din, win[PAT_W-1:1]};
    assign fill_nxt   = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
    assign cnt_nxt    = cnt + 1'b1;
    assign match      = (fill_nxt == FILL_W'(PAT_W)) &&
                        (((win_nxt ^ pat_q) & msk_q) == '0);
    assign budget_out = (cnt_nxt == CNT_W'(WIN_LEN));
    assign owner_live = |(req & gnt);

    // Control FSM with all outputs registered; result fields are only
    // non-zero in the single done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hit     <= 1'b0;
            hit_pos <= '0;
            done_id <= '0;
            pat_q   <= '0;
            msk_q   <= '0;
            win     <= '0;
            fill    <= '0;
            cnt     <= '0;
        end else begin
            done    <= 1'b0;
            hit     <= 1'b0;
            hit_pos <= '0;
            done_id <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt   <= arb_gnt;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!owner_live) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        pat_q <= pat_sel;
                        msk_q <= msk_sel;
                        win   <= '0;
                        fill  <= '0;
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!owner_live) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (bit_vld) begin
                        win  <= win_nxt;
                        fill <= fill_nxt;
                        cnt  <= cnt_nxt;
                        // A match on the last budgeted bit still reports a hit.
                        if (match || budget_out) begin
                            done    <= 1'b1;
                            hit     <= match;
                            hit_pos <= cnt_nxt;
                            done_id <= gnt;
                            gnt     <= '0;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
